// File: rtl/uart_bus_master_pkg.sv
// Shared command/response byte codes and FSM state encoding for the UART bus master.
package uart_bus_master_pkg;

  localparam logic [7:0] CmdWr  = 8'h57;
  localparam logic [7:0] CmdRd  = 8'h52;
  localparam logic [7:0] RspOk  = 8'h4B;
  localparam logic [7:0] RspBad = 8'h3F;
  localparam logic [7:0] RspErr = 8'h45;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddrH,
    StAddrL,
    StDataH,
    StDataL,
    StBus,
    StRsp0,
    StRsp1
  } state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CmdWr) || (b == CmdRd);
  endfunction

endpackage

// File: rtl/uart_bus_master_tmo_timer.sv
// Saturating timeout counter: clear wins over enable, done while the count sits at TMO_CYC.
module uart_bus_master_tmo_timer #(
  parameter int unsigned TMO_CYC = 1_200_000,
  parameter int unsigned TMO_W   = 21
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [TMO_W-1:0] Limit = TMO_W'(TMO_CYC);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == Limit);

endmodule

// File: rtl/uart_bus_master.sv
// Parses W/R command packets from the RX FIFO, runs one bus transfer, pushes the reply to TX.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TMO_CYC = 1_200_000,
  parameter int unsigned TMO_W   = 21
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rxData,
  input  logic              rxEmpty,
  output logic              rxRead,
  output logic [7:0]        txData,
  input  logic              txFull,
  output logic              txWrite,
  output logic              busReq,
  output logic              busWe,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWdata,
  input  logic [DATA_W-1:0] busRdata,
  input  logic              busAck
);

  state_e            state_q, state_d;
  logic              gap_q, gap_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        tx0_q, tx0_d;
  logic [7:0]        tx1_q, tx1_d;
  logic              two_q, two_d;

  logic pop_ok;
  logic tmr_clr, tmr_en, tmr_done;

  // The FIFO needs one cycle after a pop before rxEmpty is trustworthy again.
  assign pop_ok = !rxEmpty && !gap_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx0_d   = tx0_q;
    tx1_d   = tx1_q;
    two_d   = two_q;
    rxRead  = 1'b0;
    txWrite = 1'b0;
    txData  = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (pop_ok) begin
          rxRead  = 1'b1;
          cmd_d   = rxData;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (is_cmd(cmd_q)) begin
          we_d    = (cmd_q == CmdWr);
          state_d = StAddrH;
        end else begin
          tx0_d   = RspBad;
          two_d   = 1'b0;
          state_d = StRsp0;
        end
      end
      StAddrH, StAddrL, StDataH, StDataL: begin
        if (pop_ok) begin
          rxRead = 1'b1;
          unique case (state_q)
            StAddrH: begin addr_d[15:8]  = rxData; state_d = StAddrL; end
            StAddrL: begin addr_d[7:0]   = rxData; state_d = we_q ? StDataH : StBus; end
            StDataH: begin wdata_d[15:8] = rxData; state_d = StDataL; end
            default: begin wdata_d[7:0]  = rxData; state_d = StBus; end
          endcase
        end else if (tmr_done) begin
          state_d = StIdle;
        end
      end
      StBus: begin
        if (busAck) begin
          tx0_d   = we_q ? RspOk : busRdata[15:8];
          tx1_d   = busRdata[7:0];
          two_d   = !we_q;
          state_d = StRsp0;
        end else if (tmr_done) begin
          tx0_d   = RspErr;
          two_d   = 1'b0;
          state_d = StRsp0;
        end
      end
      StRsp0: begin
        if (!txFull) begin
          txWrite = 1'b1;
          txData  = tx0_q;
          state_d = two_q ? StRsp1 : StIdle;
        end
      end
      StRsp1: begin
        if (!txFull) begin
          txWrite = 1'b1;
          txData  = tx1_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    gap_d   = rxRead;
    tmr_clr = rxRead || ((state_d == StBus) && (state_q != StBus));
    tmr_en  = state_q inside {StAddrH, StAddrL, StDataH, StDataL, StBus};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      gap_q   <= 1'b0;
      cmd_q   <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tx0_q   <= 8'h00;
      tx1_q   <= 8'h00;
      two_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tx0_q   <= tx0_d;
      tx1_q   <= tx1_d;
      two_q   <= two_d;
    end
  end

  uart_bus_master_tmo_timer #(
    .TMO_CYC(TMO_CYC),
    .TMO_W  (TMO_W)
  ) u_tmo_timer (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .done_o(tmr_done)
  );

  assign busReq   = (state_q == StBus);
  assign busWe    = we_q;
  assign busAddr  = addr_q;
  assign busWdata = wdata_q;

endmodule
